// File: rtl/logic_axi4_stream_if.sv
// AXI4-Stream bundle shared by the logic_* stream units.
// Latency: none (wires only).
// Backpressure: tready flows against the payload; rx/tx modports name the consumer/producer side.
// Ports/signals: tvalid, tready, tdata, tkeep, tstrb, tlast, tdest, tuser, tid.
// Zero-width fields are carried as one unused bit so the bundle always elaborates.
interface logic_axi4_stream_if #(
    parameter int TDATA_BYTES = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1
) ();
    localparam int TDEST_W = (TDEST_WIDTH > 0) ? TDEST_WIDTH : 1;
    localparam int TUSER_W = (TUSER_WIDTH > 0) ? TUSER_WIDTH : 1;
    localparam int TID_W   = (TID_WIDTH > 0) ? TID_WIDTH : 1;

    logic                     tvalid;
    logic                     tready;
    logic [TDATA_BYTES*8-1:0] tdata;
    logic [TDATA_BYTES-1:0]   tkeep;
    logic [TDATA_BYTES-1:0]   tstrb;
    logic                     tlast;
    logic [TDEST_W-1:0]       tdest;
    logic [TUSER_W-1:0]       tuser;
    logic [TID_W-1:0]         tid;

    // Consumer side: the block receiving the stream.
    modport rx (input tvalid, tdata, tkeep, tstrb, tlast, tdest, tuser, tid, output tready);
    // Producer side: the block sourcing the stream.
    modport tx (output tvalid, tdata, tkeep, tstrb, tlast, tdest, tuser, tid, input tready);
endinterface

// File: rtl/logic_axi4_stream_upsizer_unit.sv
// Packs UPSIZE narrow rx beats (or fewer, up to tlast) into one wide tx beat.
// Latency: tx beat is valid one cycle after the closing rx handshake.
// Backpressure: rx.tready = !tx.tvalid || tx.tready; a stalled tx word holds rx off.
// Ports: aclk, areset_n (async, active-low), rx (narrow consumer modport), tx (wide producer modport).
module logic_axi4_stream_upsizer_unit #(
    parameter int RX_TDATA_BYTES = 1,
    parameter int TX_TDATA_BYTES = 1,
    parameter int RX_TUSER_WIDTH = 1,
    parameter int TX_TUSER_WIDTH = 1,
    parameter int TDEST_WIDTH    = 1,
    parameter int TID_WIDTH      = 1,
    parameter int USE_TLAST      = 1,
    parameter int USE_TKEEP      = 1,
    parameter int USE_TSTRB      = 1,
    parameter int UPSIZE         = TX_TDATA_BYTES / RX_TDATA_BYTES,
    parameter int INDEX_WIDTH    = (UPSIZE > 1) ? $clog2(UPSIZE) : 1
) (
    input logic             aclk,
    input logic             areset_n,
    logic_axi4_stream_if.rx rx,
    logic_axi4_stream_if.tx tx
);
    localparam int RX_DATA_W = RX_TDATA_BYTES * 8;
    localparam int TX_DATA_W = TX_TDATA_BYTES * 8;
    localparam int RX_USER_W = (RX_TUSER_WIDTH > 0) ? RX_TUSER_WIDTH : 1;
    localparam int TX_USER_W = (TX_TUSER_WIDTH > 0) ? TX_TUSER_WIDTH : 1;
    localparam int DEST_W    = (TDEST_WIDTH > 0) ? TDEST_WIDTH : 1;
    localparam int ID_W      = (TID_WIDTH > 0) ? TID_WIDTH : 1;
    // tuser handling: 0 = tied off, 1 = pass closing beat, 2 = lane-sliced like tdata.
    localparam int USER_MODE =
        (RX_TUSER_WIDTH == 0 || TX_TUSER_WIDTH == 0) ? 0 :
        (RX_TUSER_WIDTH == TX_TUSER_WIDTH)           ? 1 :
        (TX_TUSER_WIDTH == UPSIZE * RX_TUSER_WIDTH)  ? 2 : 0;
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(UPSIZE - 1);

    // Design rule checks, evaluated at elaboration.
    if (TX_TDATA_BYTES % RX_TDATA_BYTES != 0) begin : g_drc_ratio
        $error("logic_axi4_stream_upsizer_unit: TX_TDATA_BYTES must be a multiple of RX_TDATA_BYTES");
    end
    if (RX_TUSER_WIDTH > TX_TUSER_WIDTH) begin : g_drc_user_width
        $error("logic_axi4_stream_upsizer_unit: RX_TUSER_WIDTH exceeds TX_TUSER_WIDTH");
    end
    if (RX_TUSER_WIDTH > 0 && TX_TUSER_WIDTH > 0 && USER_MODE == 0) begin : g_drc_user_ratio
        $error("logic_axi4_stream_upsizer_unit: tuser width ratio not supported");
    end

    logic                         rx_rdy, rx_hsk, rx_last_eff, closing;
    logic [RX_TDATA_BYTES-1:0]    rx_keep, rx_strb;
    logic [INDEX_WIDTH-1:0]       index_d, index_q;
    logic [TX_DATA_W-1:0]         acc_data_d, acc_data_q;
    logic [TX_TDATA_BYTES-1:0]    acc_keep_d, acc_keep_q, acc_strb_d, acc_strb_q;
    logic [TX_DATA_W-1:0]         word_data;
    logic [TX_TDATA_BYTES-1:0]    word_keep, word_strb;
    logic [TX_USER_W-1:0]         user_word;
    logic                         tx_vld_d, tx_vld_q, tx_last_d, tx_last_q;
    logic [TX_DATA_W-1:0]         tx_data_d, tx_data_q;
    logic [TX_TDATA_BYTES-1:0]    tx_keep_d, tx_keep_q, tx_strb_d, tx_strb_q;
    logic [DEST_W-1:0]            tx_dest_d, tx_dest_q;
    logic [ID_W-1:0]              tx_id_d, tx_id_q;
    logic [TX_USER_W-1:0]         tx_user_d, tx_user_q;

    // Lane accumulation. The outgoing word is composed from the lanes below
    // the current index, the beat being accepted, and zeros above it, so a
    // short (tlast) word never exposes stale lanes from an earlier packet.
    always_comb begin : p_pack
        rx_rdy      = !tx_vld_q || tx.tready;
        rx_hsk      = rx.tvalid && rx_rdy;
        rx_last_eff = (USE_TLAST > 0) && rx.tlast;
        closing     = rx_hsk && ((index_q == LAST_INDEX) || rx_last_eff);
        rx_keep     = (USE_TKEEP > 0) ? rx.tkeep : {RX_TDATA_BYTES{1'b1}};
        rx_strb     = (USE_TSTRB > 0) ? rx.tstrb : {RX_TDATA_BYTES{1'b1}};
        acc_data_d  = acc_data_q;
        acc_keep_d  = acc_keep_q;
        acc_strb_d  = acc_strb_q;
        word_data   = '0;
        word_keep   = '0;
        word_strb   = '0;
        for (int l = 0; l < UPSIZE; l++) begin
            if (INDEX_WIDTH'(l) < index_q) begin
                word_data[l*RX_DATA_W +: RX_DATA_W]           = acc_data_q[l*RX_DATA_W +: RX_DATA_W];
                word_keep[l*RX_TDATA_BYTES +: RX_TDATA_BYTES] = acc_keep_q[l*RX_TDATA_BYTES +: RX_TDATA_BYTES];
                word_strb[l*RX_TDATA_BYTES +: RX_TDATA_BYTES] = acc_strb_q[l*RX_TDATA_BYTES +: RX_TDATA_BYTES];
            end else if (INDEX_WIDTH'(l) == index_q) begin
                word_data[l*RX_DATA_W +: RX_DATA_W]           = rx.tdata;
                word_keep[l*RX_TDATA_BYTES +: RX_TDATA_BYTES] = rx_keep;
                word_strb[l*RX_TDATA_BYTES +: RX_TDATA_BYTES] = rx_strb;
                if (rx_hsk) begin
                    acc_data_d[l*RX_DATA_W +: RX_DATA_W]           = rx.tdata;
                    acc_keep_d[l*RX_TDATA_BYTES +: RX_TDATA_BYTES] = rx_keep;
                    acc_strb_d[l*RX_TDATA_BYTES +: RX_TDATA_BYTES] = rx_strb;
                end
            end
        end
        index_d = index_q;
        if (rx_hsk) begin
            index_d = closing ? '0 : index_q + INDEX_WIDTH'(1);
        end
    end

    if (USER_MODE == 2) begin : g_user_slice
        logic [TX_USER_W-1:0] acc_user_d, acc_user_q;
        always_comb begin
            acc_user_d = acc_user_q;
            user_word  = '0;
            for (int l = 0; l < UPSIZE; l++) begin
                if (INDEX_WIDTH'(l) < index_q) begin
                    user_word[l*RX_USER_W +: RX_USER_W] = acc_user_q[l*RX_USER_W +: RX_USER_W];
                end else if (INDEX_WIDTH'(l) == index_q) begin
                    user_word[l*RX_USER_W +: RX_USER_W] = rx.tuser;
                    if (rx_hsk) begin
                        acc_user_d[l*RX_USER_W +: RX_USER_W] = rx.tuser;
                    end
                end
            end
        end
        always_ff @(posedge aclk) begin
            acc_user_q <= acc_user_d;
        end
    end else if (USER_MODE == 1) begin : g_user_pass
        always_comb user_word = rx.tuser;
    end else begin : g_user_none
        always_comb user_word = '0;
    end

    // Output register. A closing beat reloads it even while the previous
    // word is being taken, which is what keeps back-to-back words bubble-free.
    always_comb begin : p_tx
        tx_vld_d  = tx_vld_q;
        tx_data_d = tx_data_q;
        tx_keep_d = tx_keep_q;
        tx_strb_d = tx_strb_q;
        tx_last_d = tx_last_q;
        tx_dest_d = tx_dest_q;
        tx_id_d   = tx_id_q;
        tx_user_d = tx_user_q;
        if (closing) begin
            tx_vld_d  = 1'b1;
            tx_data_d = word_data;
            tx_keep_d = word_keep;
            tx_strb_d = word_strb;
            tx_last_d = rx_last_eff;
            tx_dest_d = rx.tdest;
            tx_id_d   = rx.tid;
            tx_user_d = user_word;
        end else if (tx.tready) begin
            tx_vld_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            tx_vld_q   <= 1'b0;
            index_q    <= '0;
            acc_keep_q <= '0;
            acc_strb_q <= '0;
        end else begin
            tx_vld_q   <= tx_vld_d;
            index_q    <= index_d;
            acc_keep_q <= acc_keep_d;
            acc_strb_q <= acc_strb_d;
        end
    end

    always_ff @(posedge aclk) begin
        acc_data_q <= acc_data_d;
        tx_data_q  <= tx_data_d;
        tx_keep_q  <= tx_keep_d;
        tx_strb_q  <= tx_strb_d;
        tx_last_q  <= tx_last_d;
        tx_dest_q  <= tx_dest_d;
        tx_id_q    <= tx_id_d;
        tx_user_q  <= tx_user_d;
    end

    assign rx.tready = rx_rdy;
    assign tx.tvalid = tx_vld_q;
    assign tx.tdata  = tx_data_q;
    assign tx.tkeep  = (USE_TKEEP > 0) ? tx_keep_q : {TX_TDATA_BYTES{1'b1}};
    assign tx.tstrb  = (USE_TSTRB > 0) ? tx_strb_q : {TX_TDATA_BYTES{1'b1}};
    assign tx.tlast  = (USE_TLAST > 0) ? tx_last_q : 1'b1;
    assign tx.tdest  = (TDEST_WIDTH > 0) ? tx_dest_q : '0;
    assign tx.tid    = (TID_WIDTH > 0) ? tx_id_q : '0;
    assign tx.tuser  = tx_user_q;
endmodule

// File: tb/tb_logic_axi4_stream_upsizer_unit.sv
// Directed bench for the 1-byte to 4-byte upsizer with lane-sliced tuser.
// Expected tx words are pushed to a queue as each packet is driven; a
// negedge monitor pops and compares every tx handshake.
module tb_logic_axi4_stream_upsizer_unit;
    logic aclk = 1'b0;
    logic areset_n = 1'b0;
    always #5 aclk = ~aclk;

    logic_axi4_stream_if #(.TDATA_BYTES(1), .TDEST_WIDTH(2), .TUSER_WIDTH(1), .TID_WIDTH(2)) rx_if ();
    logic_axi4_stream_if #(.TDATA_BYTES(4), .TDEST_WIDTH(2), .TUSER_WIDTH(4), .TID_WIDTH(2)) tx_if ();

    logic_axi4_stream_upsizer_unit #(
        .RX_TDATA_BYTES(1), .TX_TDATA_BYTES(4),
        .RX_TUSER_WIDTH(1), .TX_TUSER_WIDTH(4),
        .TDEST_WIDTH(2), .TID_WIDTH(2),
        .USE_TLAST(1), .USE_TKEEP(1), .USE_TSTRB(1)
    ) u_dut (
        .aclk    (aclk),
        .areset_n(areset_n),
        .rx      (rx_if),
        .tx      (tx_if)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic [3:0]  strb;
        logic        last;
        logic [3:0]  user;
        logic [1:0]  dest;
        logic [1:0]  id;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_got, mon_exp;
    int    checks = 0;
    int    errors = 0;
    int    last_cyc = 0;

    function automatic beat_t mk(logic [31:0] d, logic [3:0] k, logic [3:0] s, logic l,
                                 logic [3:0] u, logic [1:0] dst, logic [1:0] id);
        beat_t b;
        b.data = d; b.keep = k; b.strb = s; b.last = l;
        b.user = u; b.dest = dst; b.id = id;
        return b;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one rx beat and hold it until accepted; leaves tvalid high so
    // consecutive calls form a continuous stream.
    task automatic send(input logic [7:0] d, input logic s, input logic l, input logic u,
                        input logic [1:0] dst, input logic [1:0] id);
        logic ok;
        rx_if.tvalid = 1'b1;
        rx_if.tdata  = d;
        rx_if.tkeep  = 1'b1;
        rx_if.tstrb  = s;
        rx_if.tlast  = l;
        rx_if.tuser  = u;
        rx_if.tdest  = dst;
        rx_if.tid    = id;
        ok = 1'b0;
        last_cyc = 0;
        while (!ok && last_cyc < 100) begin
            @(negedge aclk);
            ok = (rx_if.tready === 1'b1);
            @(posedge aclk);
            last_cyc++;
        end
        #1;
        if (!ok) begin
            checks++;
            errors++;
            $error("FAIL send_timeout observed no rx handshake for data 0x%0h expected one within 100 cycles", d);
        end
    endtask

    always @(negedge aclk) begin
        if (areset_n && tx_if.tvalid === 1'b1 && tx_if.tready === 1'b1) begin
            mon_got.data = tx_if.tdata;
            mon_got.keep = tx_if.tkeep;
            mon_got.strb = tx_if.tstrb;
            mon_got.last = tx_if.tlast;
            mon_got.user = tx_if.tuser;
            mon_got.dest = tx_if.tdest;
            mon_got.id   = tx_if.tid;
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL tx_unexpected observed 0x%0h expected no beat", mon_got);
            end
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                checks++;
                assert (mon_got === mon_exp) else begin
                    errors++;
                    $error("FAIL tx_beat observed 0x%0h expected 0x%0h", mon_got, mon_exp);
                end
            end
        end
    end

    initial begin
        int n;
        rx_if.tvalid = 1'b0;
        rx_if.tdata  = '0;
        rx_if.tkeep  = '0;
        rx_if.tstrb  = '0;
        rx_if.tlast  = 1'b0;
        rx_if.tuser  = '0;
        rx_if.tdest  = '0;
        rx_if.tid    = '0;
        tx_if.tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        check("reset_tx_tvalid", tx_if.tvalid, 0);
        areset_n = 1'b1;
        check("reset_rx_tready", rx_if.tready, 1);

        // Short word closed by tlast, second lane strobe cleared.
        exp_q.push_back(mk(32'h0000BBAA, 4'h3, 4'h1, 1'b1, 4'b0011, 2'd0, 2'd0));
        send(8'hAA, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0);
        send(8'hBB, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0);
        check("short_tvalid_latency", tx_if.tvalid, 1);
        rx_if.tvalid = 1'b0;

        // Full word; must start at lane 0 after the short word.
        exp_q.push_back(mk(32'h44332211, 4'hF, 4'hF, 1'b1, 4'b0000, 2'd2, 2'd1));
        send(8'h11, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        send(8'h22, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        send(8'h33, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        check("pre_close_tvalid", tx_if.tvalid, 0);
        send(8'h44, 1'b1, 1'b1, 1'b0, 2'd2, 2'd1);
        check("full_tvalid_latency", tx_if.tvalid, 1);
        rx_if.tvalid = 1'b0;

        // Let the full word drain, then stall tx with a word pending.
        @(negedge aclk);
        @(posedge aclk);
        #1;
        tx_if.tready = 1'b0;
        exp_q.push_back(mk(32'h88776655, 4'hF, 4'hF, 1'b1, 4'b0000, 2'd0, 2'd0));
        send(8'h55, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        send(8'h66, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        send(8'h77, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        send(8'h88, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
        rx_if.tdata = 8'h99;
        rx_if.tlast = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check("stall_tdata", tx_if.tdata, 32'h88776655);
            check("stall_tvalid", tx_if.tvalid, 1);
            check("stall_rx_tready", rx_if.tready, 0);
        end
        @(posedge aclk);
        #1;
        tx_if.tready = 1'b1;
        exp_q.push_back(mk(32'h0000A099, 4'h3, 4'h3, 1'b1, 4'b0000, 2'd0, 2'd0));
        send(8'h99, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        send(8'hA0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
        rx_if.tvalid = 1'b0;

        // Continuous stream of 8 beats: two words, rx never held off.
        exp_q.push_back(mk(32'h13121110, 4'hF, 4'hF, 1'b0, 4'b0000, 2'd0, 2'd0));
        exp_q.push_back(mk(32'h17161514, 4'hF, 4'hF, 1'b1, 4'b0000, 2'd0, 2'd0));
        for (int i = 0; i < 8; i++) begin
            send(8'h10 + 8'(i), 1'b1, (i == 7), 1'b0, 2'd0, 2'd0);
            check("no_bubble_cycles", last_cyc, 1);
            if (i == 3 || i == 7) check("stream_tvalid", tx_if.tvalid, 1);
        end
        rx_if.tvalid = 1'b0;

        // Reset in the middle of a word discards the partial lanes.
        send(8'hE1, 1'b1, 1'b0, 1'b1, 2'd1, 2'd1);
        send(8'hE2, 1'b1, 1'b0, 1'b1, 2'd1, 2'd1);
        rx_if.tvalid = 1'b0;
        areset_n = 1'b0;
        #1;
        check("midreset_tvalid", tx_if.tvalid, 0);
        repeat (2) @(posedge aclk);
        #1;
        areset_n = 1'b1;
        check("post_reset_tvalid", tx_if.tvalid, 0);
        exp_q.push_back(mk(32'h04030201, 4'hF, 4'hF, 1'b1, 4'b0000, 2'd0, 2'd0));
        send(8'h01, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        send(8'h02, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        send(8'h03, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        send(8'h04, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
        rx_if.tvalid = 1'b0;

        // Lane-sliced tuser 1,0,1,1; tdest/tid from the closing beat.
        exp_q.push_back(mk(32'hD4C3B2A1, 4'hF, 4'hF, 1'b1, 4'b1101, 2'd3, 2'd2));
        send(8'hA1, 1'b1, 1'b0, 1'b1, 2'd1, 2'd0);
        send(8'hB2, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1);
        send(8'hC3, 1'b1, 1'b0, 1'b1, 2'd2, 2'd3);
        send(8'hD4, 1'b1, 1'b1, 1'b1, 2'd3, 2'd2);
        rx_if.tvalid = 1'b0;

        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(posedge aclk);
            n++;
        end
        #1;
        check("scoreboard_drain", exp_q.size(), 0);
        check("idle_tx_tvalid", tx_if.tvalid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
